// File: rtl/snake_node_scanner.sv
// snake_node_scanner: walks the snake controller's node read port over the
// live body length and reports whether a queried grid cell is body, head or apple.
module snake_node_scanner #(
  parameter int unsigned BASE_LEN  = 3,
  parameter int unsigned MAX_NODES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [5:0] cell_x,
  input  logic [5:0] cell_y,
  input  logic [3:0] cubenum,
  input  logic [5:0] apple_x,
  input  logic [5:0] apple_y,
  output logic [3:0] node,
  input  logic [5:0] node_cube_x,
  input  logic [5:0] node_cube_y,
  output logic       ready,
  output logic       valid,
  output logic       hit,
  output logic       is_head,
  output logic       apple_hit,
  output logic [3:0] hit_idx
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned COORD_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [COORD_W-1:0] cell_x_q, cell_x_nx;
  logic [COORD_W-1:0] cell_y_q, cell_y_nx;
  logic [LEN_W-1:0]   len_q, len_nx;
  logic               apple_match_q, apple_match_nx;
  logic [IDX_W-1:0]   node_nx;
  logic               ready_nx, valid_nx;
  logic               hit_nx, is_head_nx, apple_hit_nx;
  logic [IDX_W-1:0]   hit_idx_nx;
  logic [LEN_W-1:0]   len_sum_c;
  logic [LEN_W-1:0]   len_c;
  logic               match_c;

  // Active length clipped to the number of node slots the controller has.
  always_comb begin
    len_sum_c = LEN_W'(cubenum) + LEN_W'(BASE_LEN);
    len_c     = (len_sum_c > LEN_W'(MAX_NODES)) ? LEN_W'(MAX_NODES) : len_sum_c;
    match_c   = (node_cube_x == cell_x_q) && (node_cube_y == cell_y_q);
  end

  // Next-state, capture and result logic; outputs are registered from *_nx.
  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    cell_x_nx      = cell_x_q;
    cell_y_nx      = cell_y_q;
    len_nx         = len_q;
    apple_match_nx = apple_match_q;
    hit_nx         = hit;
    is_head_nx     = is_head;
    apple_hit_nx   = apple_hit;
    hit_idx_nx     = hit_idx;

    case (state)
      IDLE: begin
        if (req) begin
          cell_x_nx      = cell_x;
          cell_y_nx      = cell_y;
          len_nx         = len_c;
          apple_match_nx = (cell_x == apple_x) && (cell_y == apple_y);
          idx_nx         = '0;
          state_nx       = SCAN;
        end
      end
      SCAN: begin
        if (match_c) begin
          hit_nx       = 1'b1;
          is_head_nx   = (idx == '0);
          hit_idx_nx   = idx;
          apple_hit_nx = apple_match_q;
          state_nx     = DONE;
        end else if (LEN_W'(idx) == len_q - LEN_W'(1)) begin
          hit_nx       = 1'b0;
          is_head_nx   = 1'b0;
          hit_idx_nx   = '0;
          apple_hit_nx = apple_match_q;
          state_nx     = DONE;
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    ready_nx = (state_nx == IDLE);
    valid_nx = (state_nx == DONE);
    node_nx  = (state_nx == SCAN) ? idx_nx : '0;
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      cell_x_q      <= '0;
      cell_y_q      <= '0;
      len_q         <= '0;
      apple_match_q <= 1'b0;
      node          <= '0;
      ready         <= 1'b1;
      valid         <= 1'b0;
      hit           <= 1'b0;
      is_head       <= 1'b0;
      apple_hit     <= 1'b0;
      hit_idx       <= '0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      cell_x_q      <= cell_x_nx;
      cell_y_q      <= cell_y_nx;
      len_q         <= len_nx;
      apple_match_q <= apple_match_nx;
      node          <= node_nx;
      ready         <= ready_nx;
      valid         <= valid_nx;
      hit           <= hit_nx;
      is_head       <= is_head_nx;
      apple_hit     <= apple_hit_nx;
      hit_idx       <= hit_idx_nx;
    end
  end

endmodule

// File: doc/snake_node_scanner.md
# snake_node_scanner

Display-side consumer of the snake controller's node read port. For each grid-cell query from the VGA renderer, it drives the `node` index sequentially over the live body segments and compares each returned `node_cube_x/node_cube_y` against the queried cell. It reports whether the cell is body, head or apple. It sits between the VGA cell address generator and the snake controller, replacing free-running combinational node muxing with a deterministic request/result handshake.

## Interface
Parameters:
- `BASE_LEN`, 3: segment count at score 0.
- `MAX_NODES`, 16: node slots provided by the controller.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 1: query strobe. Accepted only when `ready`=1.
- `cell_x` in 6: queried grid column. Sampled on acceptance.
- `cell_y` in 6: queried grid row. Sampled on acceptance.
- `cubenum` in 4: controller score; sets the active length. Sampled on acceptance.
- `apple_x` in 6: apple column. Sampled on acceptance.
- `apple_y` in 6: apple row. Sampled on acceptance.
- `node` out 4: node index driven to the controller.
- `node_cube_x` in 6: x of the addressed node. Returned combinationally in the same cycle.
- `node_cube_y` in 6: y of the addressed node. Returned combinationally in the same cycle.
- `ready` out 1: scanner idle, can accept `req`.
- `valid` out 1: one-cycle result strobe.
- `hit` out 1: cell matches an active segment.
- `is_head` out 1: match was node 0.
- `apple_hit` out 1: cell equals the apple position.
- `hit_idx` out 4: index of the matching node; 0 on a miss.

## Operation
- FSM states: IDLE, SCAN, DONE. 2-bit state register.
- IDLE:
  - `ready`=1, `node`=0.
  - On `req`=1, latch `cell_x`, `cell_y`, `apple_hit`=(cell==apple), and `len`=min(`cubenum`+`BASE_LEN`, `MAX_NODES`).
  - `len` is computed in 5 bits: cubenum 0→3, 12→15, 13..15→16.
  - Clear `idx`, then go to SCAN.
- SCAN:
  - `node`=`idx`.
  - On a match (both coordinates equal the latched cell): `hit`=1, `is_head`=(`idx`==0), `hit_idx`=`idx`, go to DONE. Early termination; the lowest matching index wins.
  - Else if `idx`==`len`-1: `hit`=0, `is_head`=0, `hit_idx`=0, go to DONE.
  - Else `idx`+1.
  - `idx` is 4 bits and never wraps, because `len`≤16 bounds it at 15.
- DONE:
  - `valid`=1 for exactly this cycle, then go to IDLE.
  - `ready`=0 in DONE.
- Result hold: `hit`, `is_head`, `apple_hit` and `hit_idx` stay stable from DONE until the next accepted `req`.
- Ignored requests: `req` while in SCAN or DONE is dropped. No queueing, no error flag.
- Input snapshots:
  - `cubenum` and the apple position are snapshotted at acceptance. Later changes do not affect the scan in progress.
  - Node coordinates are read live. If the controller's game tick moves the body mid-scan, the result is taken as-is, with no retry.
- Score 15 (game-over) is treated as length 16. No special casing.

## Timing
- Reset, applied on the `clk` edge with `rst_n`=0:
  - state=IDLE, `idx`=0, `node`=0, `ready`=1 after the edge.
  - `valid`=0, `hit`=0, `is_head`=0, `apple_hit`=0, `hit_idx`=0.
- Reset mid-SCAN or mid-DONE: abort with no `valid` pulse. `rst_n` has priority over every transition.
- Acceptance at edge E. SCAN compares node 0 during cycle E..E+1.
- Match at node k: `valid` is high in cycle E+k+2, i.e. the DONE cycle.
- Miss: `valid` is high in cycle E+`len`+1.
- Worst case: 17 cycles from `req` edge to `valid`, plus 1 IDLE cycle, so 18 cycles per query.
- Back-to-back: `req` held high is re-accepted in the IDLE cycle after DONE.
- `node` is registered, or decoded from registered state only. No combinational path from `node_cube_*` to `node`.

## Test plan
- Miss, base length: body (20,15),(20,14),(20,13), cubenum=0, query (5,5), apple (9,9).
  - Expect `node` sequence 0,1,2.
  - `valid` 4 cycles after `req`; `hit`=0, `apple_hit`=0.
- Head hit: query (20,15).
  - `valid` at E+2; `hit`=1, `is_head`=1, `hit_idx`=0.
- Tail hit and length clip:
  - cubenum=13, cell placed at node 15: `valid` at E+17, `hit_idx`=15.
  - Same with cubenum=12: miss, `valid` at E+16.
- Snapshot and ignore:
  - Change `cubenum` 0→10 and pulse `req` during SCAN. The scan still covers 3 nodes, only one `valid` is produced, and the second `req` is dropped.
  - Apple query (9,9) with apple (9,9): `apple_hit`=1.
- Reset mid-scan:
  - Assert `rst_n`=0 at SCAN idx 5. The next cycle shows IDLE, `ready`=1, all result outputs 0, and no `valid` pulse.
- Back-to-back: hold `req`=1 for 3 queries.
  - `valid` pulses are separated by scan length + 2 cycles.
  - Results update only at each DONE.
